// File: rtl/rf_scoreboard_if.sv
// Decode/writeback handshake bundle for the register-file scoreboard.
// master drives decode and writeback; slave is the scoreboard.
interface rf_scoreboard_if;
  logic        issue_valid;
  logic [3:0]  p0_addr;
  logic [3:0]  p1_addr;
  logic        re0;
  logic        re1;
  logic [3:0]  dst_addr;
  logic        we;
  logic        hlt;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        flush;
  logic        stall;
  logic        issue_fire;
  logic [15:0] busy;
  logic [3:0]  pending_cnt;
  logic        halted;
  logic        wb_err;

  modport master (
    output issue_valid, p0_addr, p1_addr,
    output re0, re1, dst_addr, we, hlt,
    output wb_valid, wb_addr, flush,
    input  stall, issue_fire, busy,
    input  pending_cnt, halted, wb_err
  );

  modport slave (
    input  issue_valid, p0_addr, p1_addr,
    input  re0, re1, dst_addr, we, hlt,
    input  wb_valid, wb_addr, flush,
    output stall, issue_fire, busy,
    output pending_cnt, halted, wb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: RAW/WAW interlock, pending-write limit
// and halt drain for an in-order decode stage.
module rf_scoreboard #(
  parameter int MAX_PENDING = 4
) (
  input logic            clk,
  input logic            rst_n,
  rf_scoreboard_if.slave sb
);
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam logic [3:0] MAX_CNT = 4'(MAX_PENDING);

  logic [1:0]  state_q, state_d;
  logic [15:0] busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        halted_q, halted_d;

  logic [15:0] wb_oh, eff_busy, set_oh, clr_oh;
  logic        wb_hit, full_blk, dep, stall, fire, do_set;

  always_comb begin
    wb_oh    = sb.wb_valid ? (16'd1 << sb.wb_addr) : '0;
    eff_busy = busy_q & ~wb_oh;
    wb_hit   = sb.wb_valid & busy_q[sb.wb_addr];
    // a retiring write frees its slot in the same cycle
    full_blk = sb.we & (sb.dst_addr != 4'd0)
             & (cnt_q == MAX_CNT) & ~wb_hit;
    dep      = (sb.re0 & eff_busy[sb.p0_addr])
             | (sb.re1 & eff_busy[sb.p1_addr])
             | (sb.we  & eff_busy[sb.dst_addr]);
    stall    = sb.issue_valid
             & ((state_q == RUN) ? (dep | full_blk) : 1'b1);
    fire     = sb.issue_valid & ~stall;
    do_set   = fire & sb.we & (sb.dst_addr != 4'd0);
    set_oh   = do_set ? (16'd1 << sb.dst_addr) : '0;
    clr_oh   = wb_hit ? wb_oh : '0;

    busy_d = ((busy_q & ~clr_oh) | set_oh) & 16'hFFFE;
    cnt_d  = cnt_q + {3'b0, do_set} - {3'b0, wb_hit};
    if (sb.flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end
    err_d = err_q | (sb.wb_valid & ~busy_q[sb.wb_addr]);

    state_d = state_q;
    unique case (1'b1)
      (state_q == RUN): begin
        if (fire & sb.hlt)
          state_d = (cnt_d == 4'd0) ? HALTED : DRAIN;
      end
      (state_q == DRAIN): begin
        if (sb.flush | (cnt_d == 4'd0))
          state_d = HALTED;
      end
      default: state_d = state_q;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      busy_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  assign sb.stall       = stall;
  assign sb.issue_fire  = fire;
  assign sb.busy        = busy_q;
  assign sb.pending_cnt = cnt_q;
  assign sb.halted      = halted_q;
  assign sb.wb_err      = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard bench for rf_scoreboard: directed scenarios plus random
// traffic, checked against a set-of-pending-registers model.
module tb_rf_scoreboard;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rf_scoreboard_if sbif();

  rf_scoreboard #(.MAX_PENDING(MAXP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic stall;
    logic fire;
  } comb_t;

  typedef struct {
    logic [15:0] busy;
    logic [3:0]  cnt;
    logic        halted;
    logic        err;
  } reg_t;

  typedef enum {M_RUN, M_DRAIN, M_HALT} mst_t;

  comb_t q_comb[$];
  reg_t  q_reg[$];

  bit   pend[16];
  mst_t mst = M_RUN;
  bit   merr = 1'b0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic int npend();
    int n = 0;
    foreach (pend[i]) n += int'(pend[i]);
    return n;
  endfunction

  function automatic logic [15:0] mask();
    logic [15:0] m = '0;
    foreach (pend[i]) m[i] = pend[i];
    return m;
  endfunction

  function automatic bit effb(bit [3:0] a, bit wbv, bit [3:0] wba);
    return pend[a] && !(wbv && wba == a);
  endfunction

  task automatic drive_idle();
    sbif.issue_valid = 0; sbif.p0_addr = 0; sbif.p1_addr = 0;
    sbif.re0 = 0; sbif.re1 = 0; sbif.dst_addr = 0;
    sbif.we = 0; sbif.hlt = 0; sbif.wb_valid = 0;
    sbif.wb_addr = 0; sbif.flush = 0;
  endtask

  // One clock of stimulus; expected outputs go to the scoreboard queues.
  task automatic cyc(input bit iv, input bit [3:0] p0, input bit r0,
                     input bit [3:0] p1, input bit r1,
                     input bit [3:0] dst, input bit w, input bit h,
                     input bit wbv, input bit [3:0] wba, input bit fl);
    bit hit, stl, fire;
    comb_t c;
    reg_t r;
    @(negedge clk);
    sbif.issue_valid = iv; sbif.p0_addr = p0; sbif.re0 = r0;
    sbif.p1_addr = p1; sbif.re1 = r1; sbif.dst_addr = dst;
    sbif.we = w; sbif.hlt = h; sbif.wb_valid = wbv;
    sbif.wb_addr = wba; sbif.flush = fl;

    hit = wbv && pend[wba];
    if (mst != M_RUN) stl = iv;
    else stl = iv && ((r0 && effb(p0, wbv, wba))
                   || (r1 && effb(p1, wbv, wba))
                   || (w && effb(dst, wbv, wba))
                   || (w && dst != 0 && npend() == MAXP && !hit));
    fire = iv && !stl;

    if (wbv && !pend[wba]) merr = 1'b1;
    if (hit) pend[wba] = 1'b0;
    if (fire && w && dst != 0) pend[dst] = 1'b1;
    if (fl) pend = '{default: 1'b0};
    if (mst == M_RUN && fire && h)
      mst = (npend() == 0) ? M_HALT : M_DRAIN;
    else if (mst == M_DRAIN && (fl || npend() == 0))
      mst = M_HALT;

    c.stall = stl; c.fire = fire;
    q_comb.push_back(c);
    r.busy = mask(); r.cnt = 4'(npend());
    r.halted = (mst == M_HALT); r.err = merr;
    q_reg.push_back(r);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input bit [3:0] dst);
    cyc(1, 0, 0, 0, 0, dst, 1, 0, 0, 0, 0);
  endtask

  // Called right after cyc(): reset lands between clock edges.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    q_reg.delete();
    drive_idle();
    #1;
    chk("rst_busy", sbif.busy, 0);
    chk("rst_cnt", sbif.pending_cnt, 0);
    chk("rst_halted", sbif.halted, 0);
    chk("rst_err", sbif.wb_err, 0);
    pend = '{default: 1'b0};
    mst = M_RUN;
    merr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : comb_mon
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (q_comb.size() > 0) begin
        c = q_comb.pop_front();
        chk("stall", sbif.stall, c.stall);
        chk("issue_fire", sbif.issue_fire, c.fire);
      end
    end
  end

  initial begin : reg_mon
    reg_t r;
    forever begin
      @(posedge clk);
      #1;
      if (q_reg.size() > 0) begin
        r = q_reg.pop_front();
        chk("busy", sbif.busy, r.busy);
        chk("pending_cnt", sbif.pending_cnt, r.cnt);
        chk("halted", sbif.halted, r.halted);
        chk("wb_err", sbif.wb_err, r.err);
      end
    end
  end

  initial begin : stim
    bit [3:0] wba, dst;
    bit wbv, iv, w, h, fl;
    int busyq[$];
    drive_idle();
    #3;
    chk("init_busy", sbif.busy, 0);
    chk("init_cnt", sbif.pending_cnt, 0);
    chk("init_halted", sbif.halted, 0);
    chk("init_err", sbif.wb_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW with writeback bypass
    wr(3);
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_stall", sbif.stall, 1);
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_stall2", sbif.stall, 1);
    cyc(1, 3, 1, 0, 0, 0, 0, 0, 1, 3, 0);
    #1 chk("raw_bypass", sbif.issue_fire, 1);
    idle();
    do_reset();

    // capacity limit
    for (int i = 1; i <= 4; i++) wr(4'(i));
    idle();
    #1 chk("cap_cnt", sbif.pending_cnt, 4);
    wr(5);
    #1 chk("cap_stall", sbif.stall, 1);
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 1, 1, 0);
    #1 chk("cap_fire", sbif.issue_fire, 1);
    idle();
    #1 chk("cap_cnt2", sbif.pending_cnt, 4);
    idle();
    do_reset();

    // set wins over same-register writeback
    wr(6);
    cyc(1, 0, 0, 0, 0, 6, 1, 0, 1, 6, 0);
    idle();
    #1 chk("setwin_busy", sbif.busy, 16'h0040);
    chk("setwin_cnt", sbif.pending_cnt, 1);
    idle();
    do_reset();

    // halt drain
    wr(2);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("drain_stall", sbif.stall, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    idle();
    #1 chk("drain_halted", sbif.halted, 1);
    cyc(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    #1 chk("halt_stall", sbif.stall, 1);
    idle();
    do_reset();

    // reset in mid-drain
    wr(7);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    do_reset();
    wr(9);
    #1 chk("post_drain_rst_fire", sbif.issue_fire, 1);
    idle();
    do_reset();

    // spurious writeback is sticky across flush
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    #1 chk("err_set", sbif.wb_err, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    #1 chk("err_flush", sbif.wb_err, 1);
    idle();
    do_reset();

    // asynchronous reset with busy=0x00F0
    for (int i = 4; i <= 7; i++) wr(4'(i));
    idle();
    #1 chk("pre_async_busy", sbif.busy, 16'h00F0);
    idle();
    do_reset();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      iv = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 9) < 7);
      h = ($urandom_range(0, 39) == 0);
      fl = ($urandom_range(0, 79) == 0);
      dst = 4'($urandom);
      wbv = $urandom_range(0, 1);
      wba = 4'($urandom);
      busyq.delete();
      foreach (pend[i]) if (pend[i]) busyq.push_back(i);
      if (busyq.size() > 0 && $urandom_range(0, 9) < 8)
        wba = 4'(busyq[$urandom_range(0, busyq.size() - 1)]);
      cyc(iv, 4'($urandom), $urandom_range(0, 1),
          4'($urandom), $urandom_range(0, 1),
          dst, w, h, wbv, wba, fl);
      if ((mst == M_HALT && $urandom_range(0, 3) == 0)
          || $urandom_range(0, 199) == 0)
        do_reset();
    end

    idle();
    idle();
    #12;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 The parameter SHALL be MAX_PENDING, default 4, meaning the maximum number of outstanding register writes (range 1..15).
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 Port issue_valid SHALL be an input, 1 bit, meaning decode presents an instruction this cycle.
REQ-005 Ports p0_addr and p1_addr SHALL be inputs, 4 bits each, the source register addresses.
REQ-006 Ports re0 and re1 SHALL be inputs, 1 bit each, meaning the matching source is read.
REQ-007 Port dst_addr SHALL be an input, 4 bits, the destination register address.
REQ-008 Port we SHALL be an input, 1 bit, meaning the instruction writes dst_addr.
REQ-009 Port hlt SHALL be an input, 1 bit, meaning the instruction is a halt.
REQ-010 Port wb_valid SHALL be an input, 1 bit, meaning writeback retires a write this cycle.
REQ-011 Port wb_addr SHALL be an input, 4 bits, the retiring register address.
REQ-012 Port flush SHALL be an input, 1 bit, a synchronous scoreboard clear.
REQ-013 Port stall SHALL be a combinational output, 1 bit, meaning decode must hold.
REQ-014 Port issue_fire SHALL be a combinational output, 1 bit, equal to issue_valid & ~stall.
REQ-015 Port busy SHALL be an output, 16 bits, a registered per-register pending-write mask.
REQ-016 Port pending_cnt SHALL be an output, 4 bits, a registered count of set busy bits.
REQ-017 Port halted SHALL be an output, 1 bit, registered, high in state HALTED.
REQ-018 Port wb_err SHALL be an output, 1 bit, a registered sticky error flag.

Function
REQ-019 Register 0 SHALL never become busy; busy[0] is constant 0.
REQ-020 Effective busy SHALL be eff_busy = busy & ~(wb_valid ? onehot(wb_addr) : 0), so a same-cycle writeback bypasses.
REQ-021 Within state RUN, stall SHALL be issue_valid & ((re0 & eff_busy[p0_addr]) | (re1 & eff_busy[p1_addr]) | (we & eff_busy[dst_addr]) | (we & dst_addr!=0 & pending_cnt==MAX_PENDING & ~(wb_valid & busy[wb_addr]))).
REQ-022 Within states DRAIN and HALTED, stall SHALL equal issue_valid.
REQ-023 On issue_fire & we & dst_addr!=0, busy[dst_addr] SHALL be set at the next edge.
REQ-024 On wb_valid & busy[wb_addr], busy[wb_addr] SHALL clear, unless set in the same cycle by REQ-023; set wins.
REQ-025 A wb_valid where busy[wb_addr]==0 (including address 0) SHALL be ignored for busy and pending_cnt and SHALL set wb_err.
REQ-026 pending_cnt SHALL be updated by +1 for a set, -1 for a clear, and net 0 for both in the same cycle, so that it always equals popcount(busy).
REQ-027 The state machine SHALL have states RUN, DRAIN and HALTED.
REQ-028 RUN SHALL go to DRAIN on issue_fire & hlt; the halt's own write, if any, is recorded.
REQ-029 DRAIN SHALL go to HALTED when the next-state pending_cnt is 0.
REQ-030 HALTED SHALL be left only by reset.
REQ-031 RUN & issue_fire & hlt SHALL go directly to HALTED when the next-state pending_cnt is 0.
REQ-032 flush SHALL clear busy and pending_cnt at the next edge, overriding same-cycle sets and clears.
REQ-033 flush SHALL make a DRAIN state go to HALTED.
REQ-034 flush SHALL NOT clear wb_err and SHALL NOT change a RUN or HALTED state.

Reset
REQ-035 While rst_n=0, busy SHALL be 0, pending_cnt 0, state RUN, halted 0 and wb_err 0, all immediately and independent of clk.
REQ-036 Reset in mid-DRAIN SHALL discard all pending writes and return the block to RUN.

Verification
REQ-037 RAW: issue we dst=3; next cycle issue re0 p0=3 -> stall=1 until the wb_valid wb_addr=3 cycle, where stall=0 (bypass) and issue_fire=1.
REQ-038 Capacity (MAX_PENDING=4): four issues writing R1..R4 -> pending_cnt=4; fifth write to R5 stalls; a same-cycle wb of R1 lets it fire; pending_cnt stays 4.
REQ-039 Set-wins: busy[6]=1; issue we dst=6 with wb_valid wb_addr=6 -> busy[6]=1 and pending_cnt unchanged.
REQ-040 Halt drain: R2 busy; issue hlt -> DRAIN with stall=issue_valid; wb R2 -> halted=1 the next cycle; new issues stall permanently.
REQ-041 Spurious wb: wb_valid wb_addr=0 with busy=0 -> wb_err=1 stays set through a flush and clears only on rst_n=0.
REQ-042 Async reset: assert rst_n=0 between clock edges with busy=0x00F0 -> busy=0 and pending_cnt=0 before the next edge.
